seg_frame_decoder: RTL and testbench
====================================

Name: seg_frame_decoder

Overview:
- Receive-side counterpart of the team's seven-segment character drivers.
- Samples a time-multiplexed, active-low abcdefg segment bus plus a one-hot digit select, and filters out glitches.
- Decodes each digit's pattern back into a 5-bit character code and assembles a full frame of DIGITS characters.
- Used on boards and in benches to read back what the display logic is actually showing.

Parameters:
- DIGITS, 3: number of multiplexed digit positions (slot 0 = rightmost, led0).
- STABLE_CYC, 4: consecutive identical synchronized samples required before a capture (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset.
- seg_in  input  [0:6]  segment bus, active-low, seg_in[0]=a ... seg_in[6]=g.
- dig_sel  input  DIGITS  digit enable, active-high, one-hot when valid.
- chars  output  5*DIGITS  frame snapshot; slot k at bits [5k+4:5k].
- frame_valid  output  1  one-cycle pulse; chars updated this cycle.
- unk  output  DIGITS  per-slot flag in snapshot: pattern not in table.
- err  output  1  one-cycle pulse: stable multi-hot dig_sel seen.

Interface (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: chars=0, unk=0, frame_valid=0, err=0, slot flags cleared, counter=0.
  - Sync flops reset to seg=7'b1111111, dig_sel=0.
  - Assertion mid-frame discards any partial frame.
- Input path: seg_in and dig_sel pass through a 2-flop synchronizer (sync2 = stage-2 value).
- Stability counter:
  - Reset to 0 whenever {seg, dig_sel} in sync2 differs from the previous cycle.
  - Otherwise increments, saturating at STABLE_CYC-1.
  - A "stable event" fires exactly once per run, on the edge where the counter goes STABLE_CYC-2 -> STABLE_CYC-1.
- Latency: input held constant from edge E0 -> stable event at edge E0+STABLE_CYC+1.
- On a stable event:
  - dig_sel == 0 (blanking gap): no action.
  - dig_sel one-hot at bit k: slot k code <= decode(seg), slot k unk <= (code==31), slot k flag set. A recapture of a flagged slot overwrites it.
  - dig_sel multi-hot: err pulses the next cycle; no slot written.
- Decode table (active-low abcdefg -> code):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9
  - 0001000->10 (A), 1100000->11 (b), 0110001->12 (C), 1000010->13 (d)
  - 0110000->14 (E), 0111000->15 (F), 1001000->16 (H), 1110001->17 (L)
  - 0011000->18 (P), 1000001->19 (U), 1111110->20 (dash), 1111111->21 (blank)
  - any other pattern -> 31 (unknown)
  - All-segments-on always decodes as 8; a "B" on the display reads back as 8.
- Frame completion:
  - Completes on the edge where the last flag becomes set.
  - The completing capture is bypassed directly into the snapshot at that same edge.
  - Same edge: chars/unk updated, all flags cleared, frame_valid high for the following cycle.
  - chars/unk hold between frames.
- A new frame may begin capturing in the same cycle frame_valid is high.
- Static input never re-captures; a frame completes only after every slot has had its own stable event.

Test Plan (DIGITS=3, STABLE_CYC=4):
- Name initials: dig_sel=100 seg=0111000 for 8 cycles, then 010/0000000 for 8 cycles, then 001/0001000 for 8 cycles -> single frame_valid pulse, chars={15,8,10}, unk=000, err never high.
- Glitch filter: dig_sel=001 seg=1001111 held 3 cycles, then dig_sel=0 -> no slot flag set. Held 4 cycles -> slot 0 captured at edge E0+5.
- Multi-hot: dig_sel=011 held 6 cycles -> exactly one err pulse, no slot written, no frame_valid.
- Unknown pattern: frame with slot 1 seg=1010101 -> chars slot 1 = 31, unk=010, frame_valid still pulses.
- Overwrite and ordering: slot 2 captured as 3, then slot 2 recaptured as 5, then slots 1 and 0 captured -> chars slot 2 = 5, exactly one frame_valid.
- Reset mid-frame: slots 2 and 1 captured, rst pulsed asynchronously between edges -> outputs immediately 0. Slot 0 alone afterwards -> no frame_valid until slots 2 and 1 are recaptured.

Source files
------------

// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder: reads back a multiplexed active-low seven-segment bus.
// Synchronizes seg/digit-select, waits for a stable run, decodes each digit
// into a 5-bit character code and publishes a full frame snapshot.
module seg_frame_decoder #(
  parameter int unsigned DIGITS     = 3,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:6]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [5*DIGITS-1:0]   chars,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     unk,
  output logic                  err
);

  localparam int unsigned CW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_EV  = CW'(STABLE_CYC - 2);

  logic [0:6]          seg_s1, seg_s2, seg_prev;
  logic [DIGITS-1:0]   dig_s1, dig_s2, dig_prev;
  logic [CW-1:0]       cnt;

  logic [5*DIGITS-1:0] part_q;
  logic [DIGITS-1:0]   part_unk_q;
  logic [DIGITS-1:0]   flag_q;

  logic                same, ev, multi, onehot;
  logic [4:0]          code;
  logic [5*DIGITS-1:0] cap_part;
  logic [DIGITS-1:0]   cap_unk, cap_flag;

  function automatic logic [4:0] decode(input logic [0:6] s);
    case (s)
      7'b0000001: decode = 5'd0;
      7'b1001111: decode = 5'd1;
      7'b0010010: decode = 5'd2;
      7'b0000110: decode = 5'd3;
      7'b1001100: decode = 5'd4;
      7'b0100100: decode = 5'd5;
      7'b0100000: decode = 5'd6;
      7'b0001111: decode = 5'd7;
      7'b0000000: decode = 5'd8;
      7'b0000100: decode = 5'd9;
      7'b0001000: decode = 5'd10;
      7'b1100000: decode = 5'd11;
      7'b0110001: decode = 5'd12;
      7'b1000010: decode = 5'd13;
      7'b0110000: decode = 5'd14;
      7'b0111000: decode = 5'd15;
      7'b1001000: decode = 5'd16;
      7'b1110001: decode = 5'd17;
      7'b0011000: decode = 5'd18;
      7'b1000001: decode = 5'd19;
      7'b1111110: decode = 5'd20;
      7'b1111111: decode = 5'd21;
      default:    decode = 5'd31;
    endcase
  endfunction

  // Two-flop synchronizer, previous-sample register and stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
      dig_s1   <= '0;
      dig_s2   <= '0;
      dig_prev <= '0;
      cnt      <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      dig_s1   <= dig_sel;
      dig_s2   <= dig_s1;
      dig_prev <= dig_s2;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Stable-event detection and the would-be slot contents after a capture
  always_comb begin
    same     = (seg_s2 == seg_prev) && (dig_s2 == dig_prev);
    ev       = same && (cnt == CNT_EV);
    multi    = |(dig_s2 & (dig_s2 - DIGITS'(1)));
    onehot   = (dig_s2 != '0) && !multi;
    code     = decode(seg_s2);
    cap_part = part_q;
    cap_unk  = part_unk_q;
    cap_flag = flag_q | dig_s2;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (dig_s2[k]) begin
        cap_part[5*k +: 5] = code;
        cap_unk[k]         = (code == 5'd31);
      end
    end
  end

  // Slot capture; the completing capture goes straight into the snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_q      <= '0;
      part_unk_q  <= '0;
      flag_q      <= '0;
      chars       <= '0;
      unk         <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err         <= ev && multi;
      if (ev && onehot) begin
        part_q     <= cap_part;
        part_unk_q <= cap_unk;
        if (&cap_flag) begin
          chars       <= cap_part;
          unk         <= cap_unk;
          flag_q      <= '0;
          frame_valid <= 1'b1;
        end else begin
          flag_q <= cap_flag;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Directed bench for seg_frame_decoder (DIGITS=3, STABLE_CYC=4).
module tb_seg_frame_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:6]  seg_in;
  logic [2:0]  dig_sel;
  logic [14:0] chars;
  logic        frame_valid;
  logic [2:0]  unk;
  logic        err;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int fv_base, err_base;

  seg_frame_decoder #(.DIGITS(3), .STABLE_CYC(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_sel(dig_sel),
    .chars(chars), .frame_valid(frame_valid), .unk(unk), .err(err)
  );

  always #5 clk = ~clk;

  // pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // drive at a negedge, hold for n active edges
  task automatic hold(input logic [2:0] d, input logic [6:0] s, input int n);
    dig_sel = d;
    seg_in  = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; seg_in = 7'b1111111; dig_sel = 3'b000;
    #1;
    chk("rst_chars", 32'(chars), 0);
    chk("rst_unk", 32'(unk), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    hold(3'b000, 7'b1111111, 6);

    // initials F 8 A
    fv_base = fv_cnt; err_base = err_cnt;
    hold(3'b100, 7'b0111000, 8);
    hold(3'b010, 7'b0000000, 8);
    hold(3'b001, 7'b0001000, 8);
    hold(3'b000, 7'b1111111, 8);
    chk("init_fv", 32'(fv_cnt - fv_base), 1);
    chk("init_err", 32'(err_cnt - err_base), 0);
    chk("init_chars", 32'(chars), 32'({5'd15, 5'd8, 5'd10}));
    chk("init_unk", 32'(unk), 0);

    // multi-hot select
    fv_base = fv_cnt; err_base = err_cnt;
    hold(3'b011, 7'b0000000, 6);
    hold(3'b000, 7'b1111111, 8);
    chk("mh_err", 32'(err_cnt - err_base), 1);
    chk("mh_fv", 32'(fv_cnt - fv_base), 0);
    chk("mh_chars", 32'(chars), 32'({5'd15, 5'd8, 5'd10}));

    // 3-cycle glitch on slot 0 must not flag it
    hold(3'b001, 7'b1001111, 3);
    hold(3'b000, 7'b1111111, 6);
    hold(3'b100, 7'b0010010, 8);
    hold(3'b010, 7'b1001100, 8);
    hold(3'b000, 7'b1111111, 8);
    chk("glitch_fv", 32'(fv_cnt - fv_base), 0);
    // 4-cycle hold on slot 0 completes the frame at E0+5
    hold(3'b001, 7'b1001111, 4);
    dig_sel = 3'b000; seg_in = 7'b1111111;
    @(negedge clk);
    chk("lat_fv_e4", 32'(frame_valid), 0);
    @(negedge clk);
    chk("lat_fv_e5", 32'(frame_valid), 1);
    @(negedge clk);
    chk("lat_fv_e6", 32'(frame_valid), 0);
    hold(3'b000, 7'b1111111, 4);
    chk("lat_chars", 32'(chars), 32'({5'd2, 5'd4, 5'd1}));
    chk("lat_unk", 32'(unk), 0);

    // unknown pattern in slot 1
    fv_base = fv_cnt;
    hold(3'b100, 7'b0000001, 8);
    hold(3'b010, 7'b1010101, 8);
    hold(3'b001, 7'b1001111, 8);
    hold(3'b000, 7'b1111111, 8);
    chk("unk_fv", 32'(fv_cnt - fv_base), 1);
    chk("unk_chars", 32'(chars), 32'({5'd0, 5'd31, 5'd1}));
    chk("unk_flags", 32'(unk), 32'(3'b010));

    // overwrite of slot 2 before the frame completes
    fv_base = fv_cnt;
    hold(3'b100, 7'b0000110, 8);
    hold(3'b100, 7'b0100100, 8);
    hold(3'b010, 7'b0000100, 8);
    hold(3'b001, 7'b0001111, 8);
    hold(3'b000, 7'b1111111, 8);
    chk("ovw_fv", 32'(fv_cnt - fv_base), 1);
    chk("ovw_chars", 32'(chars), 32'({5'd5, 5'd9, 5'd7}));
    chk("ovw_unk", 32'(unk), 0);

    // asynchronous reset mid-frame discards slots 2 and 1
    hold(3'b100, 7'b0000000, 8);
    hold(3'b010, 7'b0000110, 8);
    hold(3'b000, 7'b1111111, 6);
    #2 rst = 1'b1;
    #1;
    chk("arst_chars", 32'(chars), 0);
    chk("arst_unk", 32'(unk), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    fv_base = fv_cnt;
    hold(3'b001, 7'b0100000, 8);
    hold(3'b000, 7'b1111111, 8);
    chk("arst_fv_slot0", 32'(fv_cnt - fv_base), 0);
    hold(3'b100, 7'b0000000, 8);
    hold(3'b010, 7'b0000110, 8);
    hold(3'b000, 7'b1111111, 8);
    chk("arst_fv_full", 32'(fv_cnt - fv_base), 1);
    chk("arst_chars2", 32'(chars), 32'({5'd8, 5'd3, 5'd6}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
